// File: rtl/hp_damage_unit_if.sv
// Request/response bundle between the battle control FSM (master) and the
// HP damage datapath (slave).
interface hp_damage_unit_if #(
  parameter int unsigned HP_W = 4
);
  logic            apply_damage;
  logic            active_trainer;
  logic            target;
  logic [1:0]      p_move;
  logic [1:0]      ai_move;
  logic [HP_W-1:0] p_hp;
  logic [HP_W-1:0] ai_hp;
  logic            busy;
  logic            done;
  logic            p_fainted;
  logic            ai_fainted;
  logic            overrun;

  modport master (
    output apply_damage, active_trainer, target, p_move, ai_move,
    input  p_hp, ai_hp, busy, done, p_fainted, ai_fainted, overrun
  );

  modport slave (
    input  apply_damage, active_trainer, target, p_move, ai_move,
    output p_hp, ai_hp, busy, done, p_fainted, ai_fainted, overrun
  );
endinterface

// File: rtl/hp_damage_unit.sv
// Player/AI HP owner: applies saturating move damage to the targeted Pokemon.
// Optional macro HP_DRAIN_EN: drain HP by 1 every DRAIN_CYCLES clocks instead of in one step.
module hp_damage_unit #(
  parameter int unsigned HP_W         = 4,
  parameter int unsigned MAX_HP       = 15,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  hp_damage_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [HP_W-1:0] HP_FULL = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] HP_ZERO = {HP_W{1'b0}};
  localparam logic [HP_W-1:0] HP_ONE  = {{(HP_W-1){1'b0}}, 1'b1};

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain_cycles
    $error("hp_damage_unit: DRAIN_CYCLES must be within 1..15");
  end

  function automatic logic [2:0] move_power(input logic [1:0] code);
    logic [2:0] pw;
    case (code)
      2'd0:    pw = 3'd1;
      2'd1:    pw = 3'd2;
      2'd2:    pw = 3'd3;
      2'd3:    pw = 3'd5;
      default: pw = 3'd1;
    endcase
    return pw;
  endfunction

  // The extra top bit of the difference flags an underflow, which clamps to zero.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [2:0] dmg);
    logic [HP_W:0] diff;
    diff = {1'b0, hp} - {{(HP_W-2){1'b0}}, dmg};
    if (diff[HP_W]) begin
      return HP_ZERO;
    end else begin
      return diff[HP_W-1:0];
    end
  endfunction

  state_e          state_q, state_d;
  logic            tgt_q, tgt_d;
  logic [2:0]      dmg_rem_q, dmg_rem_d;
  logic [HP_W-1:0] p_hp_q, p_hp_d;
  logic [HP_W-1:0] ai_hp_q, ai_hp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            p_fainted_q, p_fainted_d;
  logic            ai_fainted_q, ai_fainted_d;
  logic            overrun_q, overrun_d;
  logic [HP_W-1:0] cur_hp_s;
  logic [HP_W-1:0] new_hp_s;
`ifdef HP_DRAIN_EN
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  logic [3:0]      cnt_q, cnt_d;
`endif

  // Next-state logic for the damage FSM and the HP datapath.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    dmg_rem_d    = dmg_rem_q;
    p_hp_d       = p_hp_q;
    ai_hp_d      = ai_hp_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    cur_hp_s     = tgt_q ? ai_hp_q : p_hp_q;
    new_hp_s     = cur_hp_s;
`ifdef HP_DRAIN_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.apply_damage) begin
          tgt_d     = bus.target;
          dmg_rem_d = move_power(bus.active_trainer ? bus.ai_move : bus.p_move);
          busy_d    = 1'b1;
          state_d   = ST_DRAIN;
`ifdef HP_DRAIN_EN
          cnt_d     = 4'd0;
`endif
        end else begin
          busy_d    = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (bus.apply_damage) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
`ifdef HP_DRAIN_EN
        // A target already fainted leaves on the first drain edge with no damage.
        if (cur_hp_s == HP_ZERO) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == DRAIN_LAST) begin
          cnt_d     = 4'd0;
          new_hp_s  = cur_hp_s - HP_ONE;
          dmg_rem_d = dmg_rem_q - 3'd1;
          if (dmg_rem_q == 3'd1 || cur_hp_s == HP_ONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`else
        new_hp_s = sat_sub(cur_hp_s, dmg_rem_q);
        state_d  = ST_DONE;
        done_d   = 1'b1;
`endif
        if (tgt_q) begin
          ai_hp_d = new_hp_s;
        end else begin
          p_hp_d  = new_hp_s;
        end
      end

      ST_DONE: begin
        if (bus.apply_damage) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    p_fainted_d  = p_fainted_q  | (p_hp_d  == HP_ZERO);
    ai_fainted_d = ai_fainted_q | (ai_hp_d == HP_ZERO);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tgt_q        <= 1'b0;
      dmg_rem_q    <= 3'd0;
      p_hp_q       <= HP_FULL;
      ai_hp_q      <= HP_FULL;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      p_fainted_q  <= 1'b0;
      ai_fainted_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef HP_DRAIN_EN
      cnt_q        <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      dmg_rem_q    <= dmg_rem_d;
      p_hp_q       <= p_hp_d;
      ai_hp_q      <= ai_hp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      p_fainted_q  <= p_fainted_d;
      ai_fainted_q <= ai_fainted_d;
      overrun_q    <= overrun_d;
`ifdef HP_DRAIN_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.p_hp       = p_hp_q;
  assign bus.ai_hp      = ai_hp_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.p_fainted  = p_fainted_q;
  assign bus.ai_fainted = ai_fainted_q;
  assign bus.overrun    = overrun_q;

endmodule
